// File: rtl/tero_pkg.sv
// Shared types for the TERO evaluation controller: FSM states and the
// (index, count) result payload handed to the response stage.
package tero_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESEQ   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_MEASURE = 3'd3,
        ST_OUTPUT  = 3'd4,
        ST_ADVANCE = 3'd5,
        ST_FINISH  = 3'd6
    } state_e;

    localparam int unsigned RES_IDX_W = 8;
    localparam int unsigned RES_CNT_W = 16;

    typedef struct packed {
        logic [RES_IDX_W-1:0] idx;
        logic [RES_CNT_W-1:0] count;
    } result_t;

endpackage

// File: rtl/tero_window_counter.sv
// Measurement window timer plus saturating oscillation-pulse counter.
// count_c_o already includes the pulse of the current cycle.
module tero_window_counter #(
    parameter int unsigned WINDOW_CYCLES = 1024,
    parameter int unsigned CNT_BITS      = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear_i,
    input  logic                en_i,
    input  logic                pulse_i,
    output logic                last_cycle_c_o,
    output logic [CNT_BITS-1:0] count_c_o
);

    localparam int unsigned WIN_W = $clog2(WINDOW_CYCLES + 1);

    logic [WIN_W-1:0]    win_q, win_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    always_comb begin
        last_cycle_c_o = en_i && (win_q == WIN_W'(WINDOW_CYCLES - 1));
        count_c_o      = cnt_q;
        win_d          = win_q;
        cnt_d          = cnt_q;
        // Saturate instead of wrapping at all-ones.
        if (en_i && pulse_i && (cnt_q != {CNT_BITS{1'b1}})) begin
            count_c_o = cnt_q + CNT_BITS'(1);
        end
        if (clear_i) begin
            win_d = '0;
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = count_c_o;
            win_d = last_cycle_c_o ? '0 : win_q + WIN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_q <= '0;
            cnt_q <= '0;
        end else begin
            win_q <= win_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tero_eval_ctrl.sv
// Walks every TERO via the index sequencer: settle, measure a fixed window,
// and hand one (index, count) result per TERO to the consumer.
module tero_eval_ctrl
    import tero_pkg::*;
#(
    parameter int unsigned NUM_LOOPS     = 32,
    parameter int unsigned CNT_BITS      = 16,
    parameter int unsigned WINDOW_CYCLES = 1024,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned IDX_W         = $clog2(NUM_LOOPS - 1) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [IDX_W-1:0]    tero_idx,
    input  logic                seq_done,
    output logic                seq_increment,
    output logic                seq_reset,
    output logic [IDX_W-1:0]    tero_sel,
    output logic                tero_en,
    input  logic                tero_pulse,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [IDX_W-1:0]    res_idx,
    output logic [CNT_BITS-1:0] res_count,
    output logic                busy,
    output logic                done
);

    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);

    state_e              state_q, state_d;
    logic [SET_W-1:0]    settle_q, settle_d;
    logic                seq_done_q, seq_done_d;
    logic [IDX_W-1:0]    res_idx_q, res_idx_d;
    logic [CNT_BITS-1:0] res_count_q, res_count_d;
    logic                seq_increment_q, seq_increment_d;
    logic                seq_reset_q, seq_reset_d;
    logic                tero_en_q, tero_en_d;
    logic                res_valid_q, res_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                last_cycle_c;
    logic [CNT_BITS-1:0] count_c;

    tero_window_counter #(
        .WINDOW_CYCLES (WINDOW_CYCLES),
        .CNT_BITS      (CNT_BITS)
    ) u_window (
        .clk            (clk),
        .reset          (reset),
        .clear_i        (state_q == ST_SETTLE),
        .en_i           (state_q == ST_MEASURE),
        .pulse_i        (tero_pulse),
        .last_cycle_c_o (last_cycle_c),
        .count_c_o      (count_c)
    );

    // Next-state logic; outputs are decoded from the next state so they line up
    // with the state register.
    always_comb begin
        state_d     = state_q;
        settle_d    = '0;
        seq_done_d  = seq_done_q;
        res_idx_d   = res_idx_q;
        res_count_d = res_count_q;
        unique case (state_q)
            ST_IDLE:    if (start) state_d = ST_RESEQ;
            ST_RESEQ:   state_d = ST_SETTLE;
            ST_SETTLE: begin
                if (settle_q == SET_W'(SETTLE_CYCLES - 1)) state_d = ST_MEASURE;
                else settle_d = settle_q + SET_W'(1);
            end
            ST_MEASURE: begin
                if (last_cycle_c) begin
                    state_d     = ST_OUTPUT;
                    res_idx_d   = tero_idx;
                    res_count_d = count_c;
                    seq_done_d  = seq_done;
                end
            end
            ST_OUTPUT: begin
                if (res_valid_q && res_ready) state_d = seq_done_q ? ST_FINISH : ST_ADVANCE;
            end
            ST_ADVANCE: state_d = ST_SETTLE;
            ST_FINISH:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        seq_reset_d     = (state_d == ST_RESEQ);
        seq_increment_d = (state_d == ST_ADVANCE);
        tero_en_d       = (state_d == ST_MEASURE);
        res_valid_d     = (state_d == ST_OUTPUT);
        done_d          = (state_d == ST_FINISH);
        busy_d          = (state_d != ST_IDLE) && (state_d != ST_FINISH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            settle_q        <= '0;
            seq_done_q      <= 1'b0;
            res_idx_q       <= '0;
            res_count_q     <= '0;
            seq_increment_q <= 1'b0;
            seq_reset_q     <= 1'b0;
            tero_en_q       <= 1'b0;
            res_valid_q     <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            settle_q        <= settle_d;
            seq_done_q      <= seq_done_d;
            res_idx_q       <= res_idx_d;
            res_count_q     <= res_count_d;
            seq_increment_q <= seq_increment_d;
            seq_reset_q     <= seq_reset_d;
            tero_en_q       <= tero_en_d;
            res_valid_q     <= res_valid_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    assign tero_sel      = tero_idx;
    assign seq_increment = seq_increment_q;
    assign seq_reset     = seq_reset_q;
    assign tero_en       = tero_en_q;
    assign res_valid     = res_valid_q;
    assign res_idx       = res_idx_q;
    assign res_count     = res_count_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_tero_eval_ctrl.sv
// Bench for tero_eval_ctrl: two instances (4-bit and 3-bit counts) driven by a
// sequencer model and checked each cycle against a phase-based reference.
module tb_tero_eval_ctrl;
    import tero_pkg::*;

    localparam int NL = 4;
    localparam int W  = 8;
    localparam int S  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       tero_pulse = 1'b0;
    logic       res_ready = 1'b1;
    logic [2:0] seq_idx = 3'd0;
    logic       seq_done;

    logic       a_inc, a_rst, a_en, a_valid, a_busy, a_done;
    logic [2:0] a_sel, a_idx;
    logic [3:0] a_cnt;
    logic       b_inc, b_rst, b_en, b_valid, b_busy, b_done;
    logic [2:0] b_sel, b_idx;
    logic [2:0] b_cnt;

    assign seq_done = (seq_idx == 3'(NL - 1));

    always #5 clk = ~clk;

    tero_eval_ctrl #(.NUM_LOOPS(NL), .CNT_BITS(4), .WINDOW_CYCLES(W), .SETTLE_CYCLES(S)) u_dut_a (
        .clk(clk), .reset(reset), .start(start), .tero_idx(seq_idx), .seq_done(seq_done),
        .seq_increment(a_inc), .seq_reset(a_rst), .tero_sel(a_sel), .tero_en(a_en),
        .tero_pulse(tero_pulse), .res_valid(a_valid), .res_ready(res_ready),
        .res_idx(a_idx), .res_count(a_cnt), .busy(a_busy), .done(a_done)
    );

    tero_eval_ctrl #(.NUM_LOOPS(NL), .CNT_BITS(3), .WINDOW_CYCLES(W), .SETTLE_CYCLES(S)) u_dut_b (
        .clk(clk), .reset(reset), .start(start), .tero_idx(seq_idx), .seq_done(seq_done),
        .seq_increment(b_inc), .seq_reset(b_rst), .tero_sel(b_sel), .tero_en(b_en),
        .tero_pulse(tero_pulse), .res_valid(b_valid), .res_ready(res_ready),
        .res_idx(b_idx), .res_count(b_cnt), .busy(b_busy), .done(b_done)
    );

    // Index sequencer model, driven by instance A's strobes.
    always @(posedge clk) begin
        if (a_rst) seq_idx <= 3'd0;
        else if (a_inc && seq_idx != 3'(NL - 1)) seq_idx <= seq_idx + 3'd1;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_reset = 1, n_start = 0, p_mode = 0, r_mode = 0, hold_n = 0;

    // Reference model: mode 0 idle, 1 resequence, 2 inside a TERO slot.
    int m_init = 0, m_mode = 0, m_t = 0, m_out = 0, m_step = 0, m_last = 0;
    int m_cnt = 0, m_ridx = 0, m_rraw = 0;
    int done_cnt = 0, done_cyc = 0, start_cyc = 0;
    result_t q_res[$];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic compare();
        int e_rst, e_en, e_valid, e_inc, e_done, e_busy;
        if (m_init == 0) return;
        e_rst   = int'(m_mode == 1);
        e_en    = int'(m_mode == 2 && m_out == 0 && m_step == 0 && m_t >= S);
        e_valid = int'(m_mode == 2 && m_out != 0);
        e_inc   = int'(m_mode == 2 && m_step != 0 && m_last == 0);
        e_done  = int'(m_mode == 2 && m_step != 0 && m_last != 0);
        e_busy  = int'(m_mode != 0 && e_done == 0);
        chk("a_seq_reset", int'(a_rst), e_rst);
        chk("a_seq_increment", int'(a_inc), e_inc);
        chk("a_tero_en", int'(a_en), e_en);
        chk("a_res_valid", int'(a_valid), e_valid);
        chk("a_done", int'(a_done), e_done);
        chk("a_busy", int'(a_busy), e_busy);
        chk("a_tero_sel", int'(a_sel), int'(seq_idx));
        chk("a_res_idx", int'(a_idx), m_ridx);
        chk("a_res_count", int'(a_cnt), sat(m_rraw, 15));
        chk("b_seq_reset", int'(b_rst), e_rst);
        chk("b_seq_increment", int'(b_inc), e_inc);
        chk("b_tero_en", int'(b_en), e_en);
        chk("b_res_valid", int'(b_valid), e_valid);
        chk("b_done", int'(b_done), e_done);
        chk("b_busy", int'(b_busy), e_busy);
        chk("b_tero_sel", int'(b_sel), int'(seq_idx));
        chk("b_res_idx", int'(b_idx), m_ridx);
        chk("b_res_count", int'(b_cnt), sat(m_rraw, 7));
        if (e_done != 0) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic model_update();
        if (reset) begin
            m_init = 1; m_mode = 0; m_out = 0; m_step = 0; m_ridx = 0; m_rraw = 0;
        end else if (m_init != 0) begin
            if (m_mode == 0) begin
                if (start) begin
                    m_mode = 1;
                    start_cyc = cyc;
                end
            end else if (m_mode == 1) begin
                m_mode = 2; m_t = 0; m_out = 0; m_step = 0;
            end else if (m_step != 0) begin
                if (m_last != 0) m_mode = 0;
                else begin
                    m_t = 0;
                    m_step = 0;
                end
            end else if (m_out != 0) begin
                if (res_ready) begin
                    m_out = 0;
                    m_step = 1;
                    q_res.push_back('{idx: 8'(m_ridx), count: 16'(m_rraw)});
                end
            end else begin
                if (m_t == 0) m_cnt = 0;
                if (m_t >= S && tero_pulse) m_cnt++;
                if (m_t == S + W - 1) begin
                    m_ridx = int'(seq_idx);
                    m_rraw = m_cnt;
                    m_last = int'(seq_idx == 3'(NL - 1));
                    m_out  = 1;
                end
                m_t++;
            end
        end
    endtask

    // One clock: drive inputs just after the edge, check and advance the model mid-cycle.
    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        reset = (n_reset != 0);
        start = (n_start != 0);
        case (p_mode)
            0:       tero_pulse = 1'b1;
            1:       tero_pulse = cyc[0];
            default: tero_pulse = 1'($urandom_range(0, 1));
        endcase
        case (r_mode)
            0: res_ready = 1'b1;
            1: res_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (a_valid && a_idx == 3'd1 && hold_n < 5) begin
                    res_ready = 1'b0;
                    hold_n++;
                end else res_ready = 1'b1;
            end
        endcase
        @(negedge clk);
        compare();
        model_update();
    endtask

    task automatic run(input int pmode, input int rmode, input int extra_starts);
        int d0;
        q_res.delete();
        d0 = done_cnt;
        hold_n = 0;
        p_mode = pmode;
        r_mode = rmode;
        n_start = 1;
        cycle();
        n_start = 0;
        for (int i = 0; i < 400 && done_cnt == d0; i++) begin
            if (extra_starts != 0) n_start = int'($urandom_range(0, 5) == 0);
            cycle();
        end
        n_start = 0;
        chk("run_done_once", done_cnt - d0, 1);
        for (int i = 0; i < 4; i++) cycle();
        chk("no_extra_done", done_cnt - d0, 1);
        chk("result_count", q_res.size(), NL);
    endtask

    initial begin
        int found;
        for (int i = 0; i < 3; i++) cycle();
        n_reset = 0;
        cycle();
        chk("reset_busy", int'(a_busy), 0);
        chk("reset_valid", int'(a_valid), 0);
        chk("reset_count", int'(a_cnt), 0);

        // Pulses every cycle: counts 8 (A) and 7 saturated (B).
        run(0, 0, 0);
        chk("run1_latency", done_cyc - start_cyc, 49);
        for (int i = 0; i < q_res.size(); i++) begin
            chk("run1_idx", int'(q_res[i].idx), i);
            chk("run1_cnt", int'(q_res[i].count), 8);
            chk("run1_sat", sat(int'(q_res[i].count), 7), 7);
        end

        // Alternate pulses everywhere; only in-window ones count.
        run(1, 0, 0);
        chk("run2_latency", done_cyc - start_cyc, 49);
        for (int i = 0; i < q_res.size(); i++) chk("run2_cnt", int'(q_res[i].count), 4);

        // Backpressure on idx 1 for five cycles.
        run(0, 2, 0);
        chk("run3_latency", done_cyc - start_cyc, 54);
        chk("run3_hold", hold_n, 5);

        // Reset in the middle of idx 2's window.
        p_mode = 2; r_mode = 0;
        n_start = 1;
        cycle();
        n_start = 0;
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            cycle();
            if (a_en && a_sel == 3'd2) found = 1;
        end
        chk("reach_idx2", found, 1);
        cycle();
        cycle();
        n_reset = 1;
        cycle();
        n_reset = 0;
        cycle();
        chk("midrst_en", int'(a_en), 0);
        chk("midrst_busy", int'(a_busy), 0);
        chk("midrst_valid", int'(a_valid), 0);
        cycle();

        // Fresh random runs with spurious starts while busy.
        for (int r = 0; r < 3; r++) begin
            run(2, 1, 1);
            if (q_res.size() > 0) chk("rand_first_idx", int'(q_res[0].idx), 0);
            for (int i = 0; i < q_res.size(); i++) chk("rand_idx", int'(q_res[i].idx), i);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
